redpitaya_clk_rst_seq: RTL and testbench
========================================

# redpitaya_clk_rst_seq

Power-up and recovery sequencer for the ADC-clock-driven DAC PLL. It runs on the free-running ADC input clock and drives the PLL reset. It waits for a qualified lock, then releases the DAC-domain reset. On a lock timeout or lock loss it re-runs the sequence automatically, and it reports retry status to the register bank.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `pll_rst_o` is held high per attempt (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retry (≥2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- SYNC_STAGES, 3: lock synchronizer depth (≥2).
- CNT_W, 8: width of the status counters.

Ports:
- adc_clk_i  in  1  sequencer clock; the buffered ADC clock, which runs while the PLL is in reset.
- adc_rst_i  in  1  reset, asynchronous, active-high.
- pll_locked_i  in  1  PLL LOCKED; asynchronous, synchronized internally.
- restart_i  in  1  synchronous one-cycle request to re-run the sequence.
- pll_rst_o  out  1  PLL RST, active-high.
- dac_rst_o  out  1  downstream reset, active-high.
- dac_rstn_o  out  1  complement of `dac_rst_o`.
- ready_o  out  1  high only in RUN.
- state_o  out  2  0=RST_PLL, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
- retry_cnt_o  out  CNT_W  saturating count of lock timeouts.
- lost_cnt_o  out  CNT_W  saturating count of RUN→RST_PLL lock losses (present only with the macro).

## Operation
- `pll_locked_i` passes through a SYNC_STAGES flop chain. All decisions use the synchronized value `lk`.
- One down/up counter, sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), is reloaded to 0 on every state entry.
- **RST_PLL:** `pll_rst_o`=1, `dac_rst_o`=1. After RST_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst_o`=0, `dac_rst_o`=1.
  - `lk`=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT−1 with `lk`=0: increment `retry_cnt_o` (saturate at all-ones), go to RST_PLL.
- **STABLE:** `dac_rst_o`=1.
  - `lk`=0: go back to WAIT_LOCK. The timeout counter restarts and no retry is counted.
  - STABLE_CYCLES consecutive cycles with `lk`=1: go to RUN.
- **RUN:** `dac_rst_o`=0, `ready_o`=1.
  - `lk`=0: increment `lost_cnt_o` (macro on), go to RST_PLL.
- `restart_i`=1 in any state forces RST_PLL on the next cycle. It has priority over every other transition and does not touch the counters. `restart_i` in RST_PLL restarts the RST_CYCLES count.
- The status counters clear only on `adc_rst_i`.

## Timing
- Reset values: `pll_rst_o`=1, `dac_rst_o`=1, `dac_rstn_o`=0, `ready_o`=0, `state_o`=0, counters 0, synchronizer flops 0.
- All outputs are registered and decoded from the state register. Each output changes the same cycle `state_o` changes.
- `adc_rst_i` assertion mid-sequence asynchronously returns every output to its reset value. After deassertion, the sequence restarts in RST_PLL with a full RST_CYCLES.
- Lock-to-release latency: SYNC_STAGES + 1 + STABLE_CYCLES cycles from the `pll_locked_i` rise to `dac_rst_o` fall.
- Lock-loss latency: SYNC_STAGES + 1 cycles from the `pll_locked_i` fall to `dac_rst_o`=1 and `pll_rst_o`=1.
- Minimum RST_PLL dwell is exactly RST_CYCLES cycles. A timeout retry occurs exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry.

## Configuration
- **REDPITAYA_CLK_SEQ_LOST_CNT_EN defined:** the `lost_cnt_o` port and its counter exist.
- **Macro undefined:** the port and counter are absent. RUN→RST_PLL on lock loss is unchanged.

## Structure
- Shared package `redpitaya_clk_pkg` holds:
  - the 2-bit state enum and its encodings RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3;
  - the default parameter constants.
- One sub-module, `redpitaya_sync_bit` (SYNC_STAGES-deep, ASYNC_REG flops, reset to 0), synchronizes `pll_locked_i`.
- The state machine, counter and status counters live in the top module.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=3.
- **Power-up:** release reset, raise `pll_locked_i` 6 cycles later → `pll_rst_o` high 4 cycles, then `dac_rst_o` falls 12 cycles (3+1+8) after the lock rise; `ready_o`=1, `state_o`=3.
- **Timeout:** hold `pll_locked_i`=0 → `pll_rst_o` re-pulses every 24 cycles; `retry_cnt_o` increments 1, 2, 3…; with CNT_W=2 it saturates at 3.
- **Glitch in STABLE:** lock high for 5 cycles, low for 1, then high → returns to WAIT_LOCK without a retry; release occurs 8 qualified cycles after the second rise.
- **Lock loss in RUN:** drop `pll_locked_i` → `dac_rst_o`=1 and `pll_rst_o`=1 after 4 cycles; `lost_cnt_o`=1 (macro on); the port is absent with the macro off.
- **Restart and reset:** `restart_i` pulse in RUN → RST_PLL next cycle, counters unchanged. `adc_rst_i` asserted in WAIT_LOCK → all outputs at reset values immediately, counters 0.

Source files
------------

// File: rtl/redpitaya_clk_pkg.sv
// Shared state encodings and default parameters for the DAC PLL clock/reset sequencer.
package redpitaya_clk_pkg;

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Plain-vector copies of the encodings for code that keeps the state as logic [1:0].
  localparam logic [1:0] ST_RST_PLL   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES   = 3;
  localparam int DEF_CNT_W         = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/redpitaya_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module redpitaya_sync_bit #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/redpitaya_clk_rst_seq.sv
// Power-up / recovery sequencer for the ADC-clocked DAC PLL with automatic retry.
// Define REDPITAYA_CLK_SEQ_LOST_CNT_EN to add the lost_cnt_o lock-loss counter.
module redpitaya_clk_rst_seq
  import redpitaya_clk_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic             pll_locked_i,
  input  logic             restart_i,
  output logic             pll_rst_o,
  output logic             dac_rst_o,
  output logic             dac_rstn_o,
  output logic             ready_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_cnt_o
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
  ,
  output logic [CNT_W-1:0] lost_cnt_o
`endif
);

  localparam int MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW      = $clog2(MAX_CYC);

  logic          lk;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          retry_evt, lost_evt;

  redpitaya_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(adc_clk_i),
    .rst(adc_rst_i),
    .d  (pll_locked_i),
    .q  (lk)
  );

  // Restart wins over every other transition; the shared counter is zeroed on any state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (state == ST_RUN) ? cnt : cnt + CW'(1);
    retry_evt = 1'b0;
    lost_evt  = 1'b0;
    if (restart_i) begin
      state_nxt = ST_RST_PLL;
    end else begin
      case (state)
        ST_RST_PLL: begin
          if (cnt == CW'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lk) begin
            state_nxt = ST_STABLE;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state_nxt = ST_RST_PLL;
            retry_evt = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lk)                                 state_nxt = ST_WAIT_LOCK;
          else if (cnt == CW'(STABLE_CYCLES - 1))  state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!lk) begin
            state_nxt = ST_RST_PLL;
            lost_evt  = 1'b1;
          end
        end
        default: state_nxt = ST_RST_PLL;
      endcase
    end
    if (restart_i || (state_nxt != state)) cnt_nxt = '0;
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state       <= ST_RST_PLL;
      cnt         <= '0;
      pll_rst_o   <= 1'b1;
      dac_rst_o   <= 1'b1;
      dac_rstn_o  <= 1'b0;
      ready_o     <= 1'b0;
      retry_cnt_o <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_rst_o   <= (state_nxt == ST_RST_PLL);
      dac_rst_o   <= (state_nxt != ST_RUN);
      dac_rstn_o  <= (state_nxt == ST_RUN);
      ready_o     <= (state_nxt == ST_RUN);
      if (retry_evt && (retry_cnt_o != '1)) retry_cnt_o <= retry_cnt_o + CNT_W'(1);
    end
  end

  assign state_o = state;

`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i)                               lost_cnt_o <= '0;
    else if (lost_evt && (lost_cnt_o != '1))     lost_cnt_o <= lost_cnt_o + CNT_W'(1);
  end
`else
  // Lock loss still drives the state machine; only the statistic is dropped.
  logic unused_lost;
  assign unused_lost = lost_evt;
`endif

endmodule

// File: tb/tb_redpitaya_clk_rst_seq.sv
// Scenario-driven scoreboard bench for redpitaya_clk_rst_seq (REDPITAYA_CLK_SEQ_LOST_CNT_EN optional).
module tb_redpitaya_clk_rst_seq;

  localparam int CNT_W = 2;
  localparam logic [1:0] S_RST = 2'd0, S_WAIT = 2'd1, S_STABLE = 2'd2, S_RUN = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             locked;
  logic             restart;
  logic             pll_rst, dac_rst, dac_rstn, ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] retry_cnt;
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
  logic [CNT_W-1:0] lost_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [7:0] vec;
  } exp_t;
  exp_t sb[$];

  logic [7:0] obs;
  assign obs = {state, pll_rst, dac_rst, dac_rstn, ready, retry_cnt};

  redpitaya_clk_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .SYNC_STAGES  (3),
    .CNT_W        (CNT_W)
  ) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .pll_locked_i(locked),
    .restart_i   (restart),
    .pll_rst_o   (pll_rst),
    .dac_rst_o   (dac_rst),
    .dac_rstn_o  (dac_rstn),
    .ready_o     (ready),
    .state_o     (state),
    .retry_cnt_o (retry_cnt)
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
    ,
    .lost_cnt_o  (lost_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected output vector for a given state and retry count.
  function automatic logic [7:0] exp_vec(input logic [1:0] st, input logic [1:0] rc);
    logic run;
    run = (st == S_RUN);
    return {st, st == S_RST, !run, run, run, rc};
  endfunction

  task automatic push(input int at, input logic [1:0] st, input logic [1:0] rc);
    exp_t e;
    e.at  = at;
    e.vec = exp_vec(st, rc);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== exp_vec(S_RST, 2'd0))
      $display("[TB] FAIL reset_values got=%b exp=%b", obs, exp_vec(S_RST, 2'd0));
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
    checks++;
    if (lost_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_lost got=%0d exp=0", lost_cnt);
    end
`endif
    if (obs !== exp_vec(S_RST, 2'd0)) errors++;
  endtask

  task automatic test_power_up();
    exp_t e;
    sb.delete();
    push(1, S_RST, 0);  push(3, S_RST, 0);     push(4, S_WAIT, 0);
    push(9, S_WAIT, 0); push(10, S_STABLE, 0); push(17, S_STABLE, 0);
    push(18, S_RUN, 0);
    rst = 1'b0;
    for (int rel = 1; rel <= 18; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL power_up rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
      if (rel == 6) locked = 1'b1;
    end
  endtask

  task automatic test_restart();
    exp_t e;
    sb.delete();
    push(1, S_RST, 0);      push(4, S_RST, 0);     push(5, S_WAIT, 0);
    push(6, S_STABLE, 0);   push(13, S_STABLE, 0); push(14, S_RUN, 0);
    restart = 1'b1;
    for (int rel = 1; rel <= 14; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL restart rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
      if (rel == 1) restart = 1'b0;
    end
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
    checks++;
    if (lost_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL restart_lost got=%0d exp=0", lost_cnt);
    end
`endif
  endtask

  task automatic test_lock_loss();
    exp_t e;
    sb.delete();
    push(3, S_RUN, 0); push(4, S_RST, 0); push(5, S_RST, 0);
    locked = 1'b0;
    for (int rel = 1; rel <= 5; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL lock_loss rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
    end
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
    checks++;
    if (lost_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL lock_loss_cnt got=%0d exp=1", lost_cnt);
    end
`endif
  endtask

  task automatic test_glitch();
    exp_t e;
    sb.delete();
    push(1, S_RST, 0);      push(5, S_WAIT, 0);    push(8, S_WAIT, 0);
    push(9, S_STABLE, 0);   push(13, S_STABLE, 0); push(14, S_WAIT, 0);
    push(15, S_STABLE, 0);  push(22, S_STABLE, 0); push(23, S_RUN, 0);
    restart = 1'b1;
    for (int rel = 1; rel <= 23; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL glitch rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
      if (rel == 1)  restart = 1'b0;
      if (rel == 5)  locked  = 1'b1;
      if (rel == 10) locked  = 1'b0;
      if (rel == 11) locked  = 1'b1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.delete();
    push(1, S_RST, 0);   push(5, S_WAIT, 0);  push(24, S_WAIT, 0);
    push(25, S_RST, 1);  push(28, S_RST, 1);  push(29, S_WAIT, 1);
    push(49, S_RST, 2);  push(72, S_WAIT, 2); push(73, S_RST, 3);
    push(96, S_WAIT, 3); push(97, S_RST, 3);
    locked  = 1'b0;
    restart = 1'b1;
    for (int rel = 1; rel <= 97; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL timeout rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
      if (rel == 1) restart = 1'b0;
    end
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
    checks++;
    if (lost_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_lost got=%0d exp=1", lost_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    push(1, S_RST, 3);  push(5, S_WAIT, 3); push(7, S_WAIT, 3);
    push(8, S_RST, 0);  push(10, S_RST, 0); push(12, S_RST, 0);
    push(13, S_WAIT, 0);
    restart = 1'b1;
    for (int rel = 1; rel <= 13; rel++) begin
      tick();
      while (sb.size() > 0 && sb[0].at == rel) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("[TB] FAIL reset_mid rel=%0d got=%b exp=%b", rel, obs, e.vec);
        end
      end
      if (rel == 1) restart = 1'b0;
      if (rel == 7) begin
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== exp_vec(S_RST, 2'd0)) begin
          errors++;
          $display("[TB] FAIL async_reset got=%b exp=%b", obs, exp_vec(S_RST, 2'd0));
        end
`ifdef REDPITAYA_CLK_SEQ_LOST_CNT_EN
        checks++;
        if (lost_cnt !== 2'd0) begin
          errors++;
          $display("[TB] FAIL async_reset_lost got=%0d exp=0", lost_cnt);
        end
`endif
      end
      if (rel == 9) rst = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    rst     = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    test_reset();
    test_power_up();
    test_restart();
    test_lock_loss();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
